frame_buffer_pingpong: RTL and testbench
========================================

Name: frame_buffer_pingpong

Overview:
Parametrised double-buffered (ping-pong) frame store, successor to the single-bank dual-port buffer RAM. The camera capture side writes one bank while the display side reads the other. Banks swap only on a handshake: the writer reports a frame complete and the reader reports start of frame, so the display never shows a partially written frame. It sits between the camera capture block and the VGA/display driver.

Parameters:
DATA_W, 16, pixel word width (RGB565 default)
ADDR_W, 17, pixel address width per bank
DEPTH, 76800, valid pixels per bank (320x240); must be <= 2**ADDR_W
CNT_W, 8, width of the frame counter

Ports:
clk  in  1  single system clock, all logic rising-edge
rst  in  1  synchronous active-high reset
addr_in  in  ADDR_W  write pixel address within the current write bank
data_in  in  DATA_W  write pixel data
regwrite  in  1  write strobe
wr_frame_done  in  1  one-cycle pulse: writer finished the current frame
wr_ready  out  1  1 = writes accepted; 0 = swap pending, writes dropped
wr_drop  out  1  sticky: a write or frame_done arrived while wr_ready=0
addr_out  in  ADDR_W  read pixel address within the current read bank
regread  in  1  read strobe
rd_frame_start  in  1  one-cycle pulse: display starting a new frame (vsync)
data_out  out  DATA_W  registered read data
data_valid  out  1  data_out updated this cycle
wr_bank  out  1  bank currently owned by the writer
rd_bank  out  1  bank currently owned by the reader
frame_cnt  out  CNT_W  completed swaps, wraps modulo 2**CNT_W

Behaviour:
- Reset (rst=1 at a clk edge): state=FILL, wr_bank=0, rd_bank=1, wr_ready=1, wr_drop=0, data_out=0, data_valid=0, frame_cnt=0. RAM contents are not cleared. Reset mid-frame or mid-swap aborts immediately, with no swap.
- The invariant rd_bank = ~wr_bank holds at all times.
- FSM, 2 states:
  - FILL: wr_ready=1. regwrite=1 with addr_in<DEPTH writes {wr_bank,addr_in} at the edge. wr_frame_done=1 -> PENDING.
  - PENDING: wr_ready=0. regwrite is ignored and sets wr_drop. wr_frame_done is ignored and sets wr_drop. rd_frame_start=1 -> swap: wr_bank and rd_bank toggle, frame_cnt+1, -> FILL.
- In FILL, rd_frame_start is ignored: the reader keeps re-reading the old bank.
- wr_frame_done and rd_frame_start in the same cycle while in FILL: go to PENDING only. The swap waits for the next rd_frame_start.
- A write in the same cycle as wr_frame_done (FILL) is accepted into the old wr_bank.
- Read: regread=1 -> data_out = mem[{rd_bank,addr_out}] at the next edge, data_valid=1 for that one cycle. Latency is exactly 1 cycle.
- regread=0: data_out holds its last value, data_valid=0.
- A read issued in the same cycle as a swap uses the pre-swap rd_bank.
- addr_out >= DEPTH: data_out=0, data_valid=1.
- addr_in >= DEPTH: the write is ignored. wr_drop is not set.
- Writer and reader always address different banks, so no read-during-write collision case exists.
- frame_cnt wraps from 2**CNT_W-1 to 0.
- wr_drop clears only on rst.

Decomposition:
- Package fb_pkg:
  - state enum {FILL, PENDING}
  - constants BANK0=0, BANK1=1
  - default DATA_W/ADDR_W/DEPTH localparams
- Sub-module fb_ram_sdp: simple dual-port synchronous RAM of 2*DEPTH words, addressed {bank,addr}.
  - Ports: clk, we, waddr, wdata, re, raddr, rdata.
  - 1-cycle read, no reset on storage; infers block RAM.
- Top level holds the FSM, bank pointers, range checks, drop flag and counter.

Test Plan:
- Reset then idle: all outputs at reset values; wr_bank=0, rd_bank=1, wr_ready=1, frame_cnt=0.
- Writes and swap: write 0xAAAA@0, 0x8642@1, 0xFFFF@2 into bank0, pulse wr_frame_done. Expect wr_ready=0 next cycle. Pulse rd_frame_start; expect rd_bank=0, frame_cnt=1. Read addr 1 -> data_out=0x8642 with data_valid one cycle later.
- Pending protection: in PENDING, write 0x1234@1 -> wr_drop=1. After the swap, reading addr 1 still returns 0x8642.
- Simultaneous pulses in FILL: both strobes in one cycle -> state PENDING, banks unchanged, frame_cnt unchanged. The next rd_frame_start swaps the banks.
- Range: read addr 76800 -> data_out=0, data_valid=1. Write 0x5555@76800 -> no write, wr_drop unchanged. regread=0 -> data_out holds.
- Reset mid-PENDING: rst for 1 cycle -> FILL, wr_bank=0, frame_cnt=0, wr_drop=0. RAM data written before the reset is still readable after a swap.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared types and defaults for the ping-pong frame buffer.
package fb_pkg;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic BANK0 = 1'b0;
  localparam logic BANK1 = 1'b1;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 17;
  localparam int DEF_DEPTH  = 76800;
  localparam int DEF_CNT_W  = 8;

endpackage

// File: rtl/fb_ram_sdp.sv
// Simple dual-port synchronous RAM holding two banks of DEPTH words,
// addressed as {bank, addr}; one-cycle registered read, no storage reset.
module fb_ram_sdp
  import fb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W:0]   waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W:0]   raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int              WORDS    = 2 * DEPTH;
  localparam logic [ADDR_W:0] BANK_OFS = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [WORDS];

  // Bank 1 is packed directly after bank 0 so a non-power-of-two DEPTH
  // wastes no storage.
  function automatic logic [ADDR_W:0] lin(input logic [ADDR_W:0] a);
    logic [ADDR_W:0] off;
    off = {1'b0, a[ADDR_W-1:0]};
    return a[ADDR_W] ? (BANK_OFS + off) : off;
  endfunction

  always_ff @(posedge clk) begin
    if (we) mem[lin(waddr)] <= wdata;
    if (re) rdata <= mem[lin(raddr)];
  end

endmodule

// File: rtl/frame_buffer_pingpong.sv
// Double-buffered frame store: writer fills one bank, reader scans the other;
// banks swap only after writer frame-done followed by reader frame-start.
module frame_buffer_pingpong
  import fb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              regwrite,
  input  logic              wr_frame_done,
  output logic              wr_ready,
  output logic              wr_drop,
  input  logic [ADDR_W-1:0] addr_out,
  input  logic              regread,
  input  logic              rd_frame_start,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

  state_t            state, state_nx;
  logic              wb_q;
  logic              drop_q;
  logic              drop_set;
  logic              swap;
  logic              zero_q;
  logic              dv_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              wr_in_range;
  logic              rd_in_range;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign wr_in_range = ({1'b0, addr_in}  < DEPTH_LIM);
  assign rd_in_range = ({1'b0, addr_out} < DEPTH_LIM);

  always_comb begin
    state_nx = state;
    wr_ready = 1'b0;
    ram_we   = 1'b0;
    drop_set = 1'b0;
    swap     = 1'b0;
    case (state)
      FILL: begin
        wr_ready = 1'b1;
        ram_we   = regwrite && wr_in_range;
        // rd_frame_start is deliberately ignored here, even if coincident.
        if (wr_frame_done) state_nx = PENDING;
      end
      PENDING: begin
        drop_set = (regwrite && wr_in_range) || wr_frame_done;
        if (rd_frame_start) begin
          swap     = 1'b1;
          state_nx = FILL;
        end
      end
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FILL;
      wb_q   <= BANK0;
      drop_q <= 1'b0;
      cnt_q  <= '0;
      zero_q <= 1'b1;
      dv_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (swap) begin
        wb_q  <= ~wb_q;
        cnt_q <= cnt_q + 1'b1;
      end
      if (drop_set) drop_q <= 1'b1;
      dv_q <= regread;
      // RAM output register holds between reads, so only the zero-mask
      // needs tracking to make data_out hold as a whole.
      if (regread) zero_q <= !rd_in_range;
    end
  end

  assign ram_re = regread && rd_in_range;

  fb_ram_sdp #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({wb_q, addr_in}),
    .wdata (data_in),
    .re    (ram_re),
    .raddr ({~wb_q, addr_out}),
    .rdata (ram_rdata)
  );

  assign wr_drop    = drop_q;
  assign wr_bank    = wb_q;
  assign rd_bank    = ~wb_q;
  assign frame_cnt  = cnt_q;
  assign data_valid = dv_q;
  assign data_out   = zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_frame_buffer_pingpong.sv
// Directed vector bench for frame_buffer_pingpong at default parameters.
module tb_frame_buffer_pingpong;
  import fb_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 17;
  localparam int DEPTH  = 76800;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] addr_in;
  logic [DATA_W-1:0] data_in;
  logic              regwrite;
  logic              wr_frame_done;
  logic              wr_ready;
  logic              wr_drop;
  logic [ADDR_W-1:0] addr_out;
  logic              regread;
  logic              rd_frame_start;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              wr_bank;
  logic              rd_bank;
  logic [CNT_W-1:0]  frame_cnt;

  always #5 clk = ~clk;

  frame_buffer_pingpong #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .addr_in        (addr_in),
    .data_in        (data_in),
    .regwrite       (regwrite),
    .wr_frame_done  (wr_frame_done),
    .wr_ready       (wr_ready),
    .wr_drop        (wr_drop),
    .addr_out       (addr_out),
    .regread        (regread),
    .rd_frame_start (rd_frame_start),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .wr_bank        (wr_bank),
    .rd_bank        (rd_bank),
    .frame_cnt      (frame_cnt)
  );

  typedef struct {
    logic        rst;
    logic        we;
    int unsigned ai;
    int unsigned di;
    logic        fd;
    logic        re;
    int unsigned ao;
    logic        fs;
    logic        e_rdy;
    logic        e_drop;
    logic        e_wb;
    int unsigned e_cnt;
    logic        e_dv;
    int unsigned e_dout;
  } vec_t;

  vec_t vecs[$];
  int   total  = 0;
  int   passed = 0;

  function automatic vec_t mk(logic r, logic w, int unsigned ai, int unsigned di,
                              logic fd, logic rd, int unsigned ao, logic fs,
                              logic rdy, logic drop, logic wb, int unsigned cnt,
                              logic dv, int unsigned dout);
    vec_t v;
    v.rst = r; v.we = w; v.ai = ai; v.di = di; v.fd = fd;
    v.re = rd; v.ao = ao; v.fs = fs;
    v.e_rdy = rdy; v.e_drop = drop; v.e_wb = wb; v.e_cnt = cnt;
    v.e_dv = dv; v.e_dout = dout;
    return v;
  endfunction

  task automatic check(input string name, input int idx,
                       input int unsigned act, input int unsigned exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; regwrite = 1'b0; wr_frame_done = 1'b0; regread = 1'b0;
    rd_frame_start = 1'b0; addr_in = '0; data_in = '0; addr_out = '0;
  endtask

  initial begin
    //              rst we  ai      di     fd  re  ao     fs   rdy drop wb cnt dv dout
    vecs.push_back(mk(1, 0, 0,      0,      0, 0, 0,      0,   1, 0, 0, 0, 0, 0));      // 0 reset
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      0,   1, 0, 0, 0, 0, 0));      // 1 idle
    vecs.push_back(mk(0, 1, 0,      'hAAAA, 0, 0, 0,      0,   1, 0, 0, 0, 0, 0));      // 2
    vecs.push_back(mk(0, 1, 1,      'h8642, 0, 0, 0,      0,   1, 0, 0, 0, 0, 0));      // 3
    vecs.push_back(mk(0, 1, 2,      'hFFFF, 0, 0, 0,      0,   1, 0, 0, 0, 0, 0));      // 4
    vecs.push_back(mk(0, 0, 0,      0,      1, 0, 0,      0,   0, 0, 0, 0, 0, 0));      // 5 done
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      1,   1, 0, 1, 1, 0, 0));      // 6 swap
    vecs.push_back(mk(0, 0, 0,      0,      0, 1, 1,      0,   1, 0, 1, 1, 1, 'h8642)); // 7 read
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      0,   1, 0, 1, 1, 0, 'h8642)); // 8 hold
    vecs.push_back(mk(0, 1, 1,      'h0BAD, 0, 0, 0,      0,   1, 0, 1, 1, 0, 'h8642)); // 9 bank1
    vecs.push_back(mk(0, 0, 0,      0,      1, 0, 0,      0,   0, 0, 1, 1, 0, 'h8642)); // 10 done
    vecs.push_back(mk(0, 1, 1,      'h1234, 0, 1, 1,      0,   0, 1, 1, 1, 1, 'h8642)); // 11 dropped
    vecs.push_back(mk(0, 0, 0,      0,      0, 1, 2,      1,   1, 1, 0, 2, 1, 'hFFFF)); // 12 pre-swap read
    vecs.push_back(mk(0, 0, 0,      0,      0, 1, 1,      0,   1, 1, 0, 2, 1, 'h0BAD)); // 13
    vecs.push_back(mk(0, 0, 0,      0,      1, 0, 0,      1,   0, 1, 0, 2, 0, 'h0BAD)); // 14 both
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      0,   0, 1, 0, 2, 0, 'h0BAD)); // 15
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      1,   1, 1, 1, 3, 0, 'h0BAD)); // 16 swap
    vecs.push_back(mk(0, 0, 0,      0,      1, 0, 0,      0,   0, 1, 1, 3, 0, 'h0BAD)); // 17 done
    vecs.push_back(mk(1, 0, 0,      0,      0, 0, 0,      0,   1, 0, 0, 0, 0, 0));      // 18 reset
    vecs.push_back(mk(0, 0, 0,      0,      1, 0, 0,      0,   0, 0, 0, 0, 0, 0));      // 19
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      1,   1, 0, 1, 1, 0, 0));      // 20 swap
    vecs.push_back(mk(0, 0, 0,      0,      0, 1, 0,      0,   1, 0, 1, 1, 1, 'hAAAA)); // 21 survives
    vecs.push_back(mk(0, 0, 0,      0,      0, 1, DEPTH,  0,   1, 0, 1, 1, 1, 0));      // 22 oor read
    vecs.push_back(mk(0, 1, DEPTH,  'h5555, 0, 0, 0,      0,   1, 0, 1, 1, 0, 0));      // 23 oor write
    vecs.push_back(mk(0, 0, 0,      0,      0, 1, 2,      0,   1, 0, 1, 1, 1, 'hFFFF)); // 24
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      0,   1, 0, 1, 1, 0, 'hFFFF)); // 25 hold
    vecs.push_back(mk(0, 1, DEPTH-1,'h7777, 0, 0, 0,      0,   1, 0, 1, 1, 0, 'hFFFF)); // 26 last addr
    vecs.push_back(mk(0, 0, 0,      0,      1, 0, 0,      0,   0, 0, 1, 1, 0, 'hFFFF)); // 27
    vecs.push_back(mk(0, 0, 0,      0,      0, 0, 0,      1,   1, 0, 0, 2, 0, 'hFFFF)); // 28
    vecs.push_back(mk(0, 0, 0,      0,      0, 1, DEPTH-1,0,   1, 0, 0, 2, 1, 'h7777)); // 29

    idle_inputs();
    rst = 1'b1;
    #2;
    foreach (vecs[i]) begin
      rst            = vecs[i].rst;
      regwrite       = vecs[i].we;
      addr_in        = ADDR_W'(vecs[i].ai);
      data_in        = DATA_W'(vecs[i].di);
      wr_frame_done  = vecs[i].fd;
      regread        = vecs[i].re;
      addr_out       = ADDR_W'(vecs[i].ao);
      rd_frame_start = vecs[i].fs;
      @(posedge clk);
      #1;
      check("wr_ready",   i, 32'(wr_ready),   32'(vecs[i].e_rdy));
      check("wr_drop",    i, 32'(wr_drop),    32'(vecs[i].e_drop));
      check("wr_bank",    i, 32'(wr_bank),    32'(vecs[i].e_wb));
      check("rd_bank",    i, 32'(rd_bank),    32'(!vecs[i].e_wb));
      check("frame_cnt",  i, 32'(frame_cnt),  vecs[i].e_cnt);
      check("data_valid", i, 32'(data_valid), 32'(vecs[i].e_dv));
      check("data_out",   i, 32'(data_out),   vecs[i].e_dout);
    end

    // Counter wrap: from 2 swaps, another 254 complete the modulo-256 cycle.
    idle_inputs();
    for (int unsigned n = 0; n < 254; n++) begin
      wr_frame_done = 1'b1;
      @(posedge clk); #1;
      wr_frame_done = 1'b0;
      rd_frame_start = 1'b1;
      @(posedge clk); #1;
      rd_frame_start = 1'b0;
      if (n == 252) check("frame_cnt_255", 252, 32'(frame_cnt), 255);
    end
    check("frame_cnt_wrap", 253, 32'(frame_cnt), 0);
    check("wr_bank_wrap",   253, 32'(wr_bank),   0);
    check("wr_drop_wrap",   253, 32'(wr_drop),   0);

    // Drop via a repeated frame_done while a swap is pending.
    wr_frame_done = 1'b1;
    @(posedge clk); #1;
    check("pending_rdy", 300, 32'(wr_ready), 0);
    @(posedge clk); #1;
    wr_frame_done = 1'b0;
    check("done_drop",   301, 32'(wr_drop),  1);
    check("done_cnt",    301, 32'(frame_cnt), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
